// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, LSB-first data, optional parity, one stop bit
module uart_tx_serializer #(
    parameter int Data_Width     = 8,
    parameter int Prescale_Width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [Data_Width-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_Width-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int BCW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [Prescale_Width-1:0] MIN_PRESC = Prescale_Width'(4);
    localparam logic [Prescale_Width-1:0] ONE_EDGE  = Prescale_Width'(1);
    localparam logic [BCW-1:0]            LAST_BIT  = BCW'(Data_Width - 1);
    localparam logic [BCW-1:0]            ONE_BIT   = BCW'(1);

    logic [2:0]                state_q, state_d;
    logic [Prescale_Width-1:0] edge_q, edge_d;
    logic [BCW-1:0]            bit_q, bit_d;
    logic [Data_Width-1:0]     shift_q, shift_d;
    logic [Prescale_Width-1:0] presc_q, presc_d;
    logic                      par_en_q, par_en_d;
    logic                      parity_q, parity_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      bit_wrap;
    logic [Prescale_Width-1:0] presc_eff;

    // Too-short bit periods are clamped so the line never runs faster than four clocks per bit.
    assign presc_eff = (Prescale < MIN_PRESC) ? MIN_PRESC : Prescale;
    assign bit_wrap  = (state_q != ST_IDLE) && (edge_q == (presc_q - ONE_EDGE));

    always_comb begin
        state_d  = state_q;
        edge_d   = edge_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        presc_d  = presc_q;
        par_en_d = par_en_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;

        if (state_q != ST_IDLE) begin
            edge_d = bit_wrap ? '0 : (edge_q + ONE_EDGE);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                edge_d = '0;
                bit_d  = '0;
                if (Data_Valid) begin
                    shift_d  = P_DATA;
                    presc_d  = presc_eff;
                    par_en_d = PAR_EN;
                    parity_d = (^P_DATA) ^ PAR_TYP;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_wrap) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + ONE_BIT;
                        tx_d  = shift_d[0];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_wrap) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                // Busy drops on the final stop-bit edge so a request can be taken on the very next cycle.
                if (bit_wrap) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                edge_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            edge_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            presc_q  <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            presc_q  <= presc_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed-vector bench for uart_tx_serializer
module tb_uart_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int vectors = 0;
    int miscompares = 0;

    logic tx_s [0:599];
    int   busy_len;
    logic idle_tx;
    logic idle_busy;
    logic obs_bit [0:11];
    logic stable  [0:11];

    uart_tx_serializer #(.Data_Width(8), .Prescale_Width(6)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
    endtask

    // Records the line while Busy is high (bounded), then splits it into bit periods of p cycles.
    task automatic capture(input int p);
        bit done = 0;
        busy_len = 0;
        while (!done && busy_len < 600) begin
            @(negedge CLK);
            if (Busy === 1'b1) begin
                tx_s[busy_len] = TX_OUT;
                busy_len++;
            end else begin
                done = 1;
            end
        end
        idle_tx = TX_OUT;
        idle_busy = Busy;
        for (int i = 0; i < 12; i++) begin
            obs_bit[i] = (i * p < busy_len) ? tx_s[i * p] : 1'bx;
            stable[i] = 1'b1;
            for (int j = 0; j < p; j++)
                if (i * p + j >= busy_len || tx_s[i * p + j] !== obs_bit[i]) stable[i] = 1'b0;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        #2;
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: TX_OUT=%b Busy=%b, expected TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
    endtask

    task automatic test_no_parity;
        logic [9:0] e = 10'b1101001010;
        start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
        capture(8);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e[i]) begin
                miscompares++;
                $display("FAIL a5_p8 bit %0d: got %b (held %b), expected %b held 8 cycles", i, obs_bit[i], stable[i], e[i]);
            end
        end
        vectors++;
        if (busy_len != 80 || idle_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_p8 length: busy %0d cycles, idle TX %b; expected 80 cycles, TX 1", busy_len, idle_tx);
        end
    endtask

    task automatic test_parity;
        logic [10:0] e_even = 11'b10101001010;
        logic [10:0] e_odd  = 11'b11101001010;
        logic [10:0] e_07   = 11'b10000001110;
        start_frame(8'hA5, 1'b1, 1'b0, 6'd16);
        capture(16);
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e_even[i]) begin
                miscompares++;
                $display("FAIL a5_even bit %0d: got %b (held %b), expected %b", i, obs_bit[i], stable[i], e_even[i]);
            end
        end
        vectors++;
        if (busy_len != 176) begin
            miscompares++;
            $display("FAIL a5_even length: busy %0d cycles, expected 176", busy_len);
        end
        start_frame(8'hA5, 1'b1, 1'b1, 6'd16);
        capture(16);
        vectors++;
        if (!stable[9] || obs_bit[9] !== e_odd[9] || !stable[10] || obs_bit[10] !== e_odd[10] || busy_len != 176) begin
            miscompares++;
            $display("FAIL a5_odd parity/stop: got %b%b len %0d, expected %b%b len 176", obs_bit[9], obs_bit[10], busy_len, e_odd[9], e_odd[10]);
        end
        start_frame(8'h07, 1'b1, 1'b1, 6'd32);
        capture(32);
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e_07[i]) begin
                miscompares++;
                $display("FAIL x07_odd bit %0d: got %b (held %b), expected %b", i, obs_bit[i], stable[i], e_07[i]);
            end
        end
        vectors++;
        if (busy_len != 352) begin
            miscompares++;
            $display("FAIL x07_odd length: busy %0d cycles, expected 352", busy_len);
        end
    endtask

    task automatic test_ignore_busy;
        logic [9:0] e = 10'b1100000010;
        start_frame(8'h81, 1'b0, 1'b0, 6'd8);
        fork
            capture(8);
            begin
                repeat (20) @(negedge CLK);
                P_DATA = 8'h3C; PAR_EN = 1'b1; Prescale = 6'd4; Data_Valid = 1'b1;
                @(negedge CLK);
                Data_Valid = 1'b0;
            end
        join
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e[i]) begin
                miscompares++;
                $display("FAIL x81_ignore bit %0d: got %b (held %b), expected %b", i, obs_bit[i], stable[i], e[i]);
            end
        end
        repeat (4) @(negedge CLK);
        vectors++;
        if (busy_len != 80 || Busy !== 1'b0 || TX_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL x81_ignore tail: len %0d Busy %b TX %b, expected 80, 0, 1", busy_len, Busy, TX_OUT);
        end
        PAR_EN = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0] e = 10'b1010101010;
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
        @(posedge CLK);
        capture(4);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e[i]) begin
                miscompares++;
                $display("FAIL x55_first bit %0d: got %b (held %b), expected %b", i, obs_bit[i], stable[i], e[i]);
            end
        end
        vectors++;
        if (busy_len != 40 || idle_tx !== 1'b1 || idle_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL x55_gap: len %0d idle TX %b Busy %b, expected 40, 1, 0", busy_len, idle_tx, idle_busy);
        end
        fork
            capture(4);
            begin
                @(posedge CLK);
                #1 Data_Valid = 1'b0;
            end
        join
        vectors++;
        if (busy_len != 40 || obs_bit[0] !== 1'b0 || obs_bit[1] !== 1'b1 || obs_bit[9] !== 1'b1) begin
            miscompares++;
            $display("FAIL x55_second: len %0d bits %b%b..%b, expected 40 with 01..1", busy_len, obs_bit[0], obs_bit[1], obs_bit[9]);
        end
    endtask

    task automatic test_async_reset;
        logic [9:0] e = 10'b1111100000;
        start_frame(8'h00, 1'b0, 1'b0, 6'd8);
        repeat (20) @(negedge CLK);
        vectors++;
        if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: TX_OUT=%b Busy=%b, expected 0 1", TX_OUT, Busy);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: TX_OUT=%b Busy=%b, expected 1 0 without a clock edge", TX_OUT, Busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        start_frame(8'hF0, 1'b0, 1'b0, 6'd8);
        capture(8);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e[i]) begin
                miscompares++;
                $display("FAIL xf0_after_reset bit %0d: got %b (held %b), expected %b", i, obs_bit[i], stable[i], e[i]);
            end
        end
        vectors++;
        if (busy_len != 80) begin
            miscompares++;
            $display("FAIL xf0_after_reset length: busy %0d, expected 80", busy_len);
        end
    endtask

    task automatic test_clamp;
        logic [9:0] e = 10'b1000000010;
        start_frame(8'h01, 1'b0, 1'b0, 6'd2);
        capture(4);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (!stable[i] || obs_bit[i] !== e[i]) begin
                miscompares++;
                $display("FAIL clamp bit %0d: got %b (held %b), expected %b held 4 cycles", i, obs_bit[i], stable[i], e[i]);
            end
        end
        vectors++;
        if (busy_len != 40) begin
            miscompares++;
            $display("FAIL clamp length: busy %0d, expected 40", busy_len);
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit half of the UART link; mirrors the receive path's frame format (start, 8 data bits LSB first, optional parity, one stop bit). Accepts a parallel byte with a valid strobe, then serializes it on TX_OUT. Runs on the same oversampled clock as the receiver and holds each bit for exactly Prescale clocks, so one Prescale setting drives both directions. Contains a frame FSM, a bit-period (edge) counter, a bit counter, a shift register and a parity generator.

Parameters:
Data_Width, 8, data bits per frame; bit counter sized to cover it
Prescale_Width, 6, width of Prescale and of the internal edge counter

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
P_DATA  input  Data_Width  byte to transmit, sampled only on acceptance
Data_Valid  input  1  request strobe; accepted only when Busy=0
PAR_EN  input  1  1 = insert parity bit after data
PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
Prescale  input  Prescale_Width  clocks per bit; sampled on acceptance
TX_OUT  output  1  serial line, idle high
Busy  output  1  high while a frame is in progress

Behaviour:
- Reset (asynchronous, active-high): TX_OUT=1, Busy=0, FSM=IDLE, edge/bit counters=0, shift and config registers=0. Takes effect immediately, including mid-frame; the partial frame is abandoned, with no resume.
- FSM states: IDLE -> START -> DATA -> (PARITY if latched PAR_EN) -> STOP -> IDLE.
- IDLE: TX_OUT=1, Busy=0. Data_Valid=1 at rising edge k:
  - latch P_DATA, PAR_EN, PAR_TYP and effective Prescale;
  - compute parity = XOR(P_DATA) XOR PAR_TYP;
  - go to START. From cycle k+1: TX_OUT=0, Busy=1.
- Effective Prescale: the input value, except values below 4 are clamped to 4. The bit period is fixed for the whole frame; input changes mid-frame are ignored.
- Edge counter: counts 0..Prescale-1 within each bit and wraps to 0 on the last clock of the bit. Each state advances only on that wrap, so every bit lasts exactly Prescale cycles.
- START: TX_OUT=0 for one bit period.
- DATA: TX_OUT=shift[0] (LSB first). On each bit wrap, shift right and increment the bit counter. After bit Data_Width-1, go to PARITY or STOP and clear the bit counter.
- PARITY: TX_OUT=latched parity bit for one bit period.
- STOP: TX_OUT=1 for one bit period. On the final wrap, return to IDLE with Busy=0 in the same cycle.
- Frame length: (Data_Width+2+PAR_EN)*Prescale cycles from cycle k+1. Busy is high for exactly this many cycles.
- Data_Valid while Busy=1: ignored with no queuing; the latched byte and config are unchanged.
- Minimum gap between frames: a request may be accepted on the first IDLE cycle after STOP. Consecutive frames therefore have one idle-high cycle between stop bit and next start bit.
- Data_Valid held high continuously: a new frame starts on every IDLE cycle.
- TX_OUT is driven from a register, glitch-free; it changes only on CLK edges or reset.

Test Plan:
- Reset, then P_DATA=0xA5, PAR_EN=0, Prescale=8, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; Busy high exactly 80 cycles; TX_OUT=1 afterwards.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=16 -> parity bit 0 after bit7; frame 176 cycles. Repeat with PAR_TYP=1 -> parity bit 1.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=1, Prescale=32 -> data 1,1,1,0,0,0,0,0, then parity 0; Busy high 352 cycles.
- Pulse Data_Valid with 0x3C mid-frame while sending 0x81 -> line shows only 0x81. Hold Data_Valid high with 0x55 -> frames start exactly 1 idle cycle apart.
- Assert RST at cycle 20 of a Prescale=8 frame -> TX_OUT=1 and Busy=0 within the same cycle, with no clock edge needed. After release, new byte 0xF0 transmits correctly.
- Prescale=2 with 0x01 -> clamped; each bit lasts 4 cycles, frame 40 cycles.
